mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store).
- Arbitrates between the two, sequences each variable-latency memory transaction with a req/ready handshake, and returns per-requester done pulses and stall signals.
- Stalls are ORed by the pipeline with the hazard unit's stall.
- MEM has priority as the older instruction; a streak counter guarantees fetch progress.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions: arbiter state encoding and the load/store
// opcodes the MEM stage decodes into mem_req/mem_we.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IF   = 2'd1;
  localparam logic [1:0] ARB_MEM  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ARB_IDLE,
    S_IF   = ARB_IF,
    S_MEM  = ARB_MEM
  } arb_state_t;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;

  function automatic logic op_is_mem(input logic [6:0] opcode);
    return (opcode == LW) || (opcode == SW);
  endfunction

  function automatic logic op_is_store(input logic [6:0] opcode);
    return opcode == SW;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (IF/MEM) and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requesters raise *_req and hold it with its fields stable until the
  // one-cycle *_done pulse; *_rdata is valid only while *_done=1.
  // The memory sees m_req with m_* stable until it returns m_ready=1, which
  // completes the transfer in that same cycle (m_rdata valid alongside).
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata, m_ready,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata, m_ready,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    input  m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store; MEM wins
// ties unless it has been granted MAX_MEM_STREAK times while IF waited.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output arb_state_t          dbg_state,
  output logic [3:0]          dbg_streak
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

  arb_state_t        state, state_nxt;
  logic [3:0]        streak, streak_nxt;
  logic              req_q, req_nxt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;

  logic if_fin, mem_fin, decide, if_cand, mem_cand, grant_if, grant_mem;

  assign if_fin   = (state == S_IF)  && bus.m_ready;
  assign mem_fin  = (state == S_MEM) && bus.m_ready;
  // Any non-serving encoding decides every cycle, so a stray state recovers.
  assign decide   = !((state == S_IF) || (state == S_MEM)) || bus.m_ready;
  // A requester finishing this cycle still shows req high; it is not a new request.
  assign if_cand  = bus.if_req  && !if_fin;
  assign mem_cand = bus.mem_req && !mem_fin;
  assign grant_if  = if_cand && (!mem_cand || (streak == STREAK_MAX));
  assign grant_mem = mem_cand && !grant_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      streak  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      req_q   <= req_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    req_nxt    = req_q;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    if (decide) begin
      if (grant_if) begin
        state_nxt  = S_IF;
        req_nxt    = 1'b1;
        we_nxt     = 1'b0;
        addr_nxt   = bus.if_addr;
        streak_nxt = '0;
      end else if (grant_mem) begin
        state_nxt  = S_MEM;
        req_nxt    = 1'b1;
        we_nxt     = bus.mem_we;
        addr_nxt   = bus.mem_addr;
        wdata_nxt  = bus.mem_wdata;
        if (!bus.if_req)
          streak_nxt = '0;
        else if (streak != STREAK_MAX)
          streak_nxt = streak + 4'd1;
      end else begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    end
  end

  assign bus.m_req     = req_q;
  assign bus.m_we      = we_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.if_done   = if_fin;
  assign bus.mem_done  = mem_fin;
  assign bus.if_rdata  = bus.m_rdata;
  assign bus.mem_rdata = bus.m_rdata;
  assign bus.if_stall  = bus.if_req  & ~if_fin;
  assign bus.mem_stall = bus.mem_req & ~mem_fin;

  assign dbg_state  = state;
  assign dbg_streak = streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table plus wait-state, hold and
// reset sequences, with a read-data/store scoreboard on the done pulses.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  arb_state_t dbg_state;
  logic [3:0] dbg_streak;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(4)) dut (
    .clk(clk), .rst(rst_n), .bus(bus), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // Memory model: manual m_ready, or automatic with ws wait states.
  logic       auto_mode = 1'b0;
  logic       man_ready = 1'b0;
  logic [7:0] ws = 8'd0;
  logic [7:0] wcnt;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign bus.m_rdata = mem_word(bus.m_addr);
  assign bus.m_ready = auto_mode ? (bus.m_req && (wcnt == ws)) : man_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= '0;
    else if (bus.m_req && !bus.m_ready) wcnt <= wcnt + 8'd1;
    else wcnt <= '0;
  end

  int total = 0;
  int bad = 0;

  logic [DW-1:0]    if_exp_q[$];
  logic [DW-1:0]    mem_exp_q[$];
  logic [AW+DW-1:0] st_exp_q[$];
  bit if_pend = 0;
  bit mem_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sb_sample();
    if (bus.if_req && !if_pend) begin
      if_exp_q.push_back(mem_word(bus.if_addr));
      if_pend = 1;
    end
    if (bus.mem_req && !mem_pend) begin
      if (bus.mem_we) st_exp_q.push_back({bus.mem_addr, bus.mem_wdata});
      else mem_exp_q.push_back(mem_word(bus.mem_addr));
      mem_pend = 1;
    end
    if (bus.if_done) begin
      chk("if_done_has_req", 64'(if_exp_q.size() != 0), 64'd1);
      if (if_exp_q.size() != 0) chk("if_rdata", 64'(bus.if_rdata), 64'(if_exp_q.pop_front()));
      if_pend = 0;
    end
    if (bus.mem_done) begin
      if (bus.mem_we) begin
        chk("store_has_req", 64'(st_exp_q.size() != 0), 64'd1);
        if (st_exp_q.size() != 0) chk("store_beat", {bus.m_addr, bus.m_wdata}, st_exp_q.pop_front());
      end else begin
        chk("load_has_req", 64'(mem_exp_q.size() != 0), 64'd1);
        if (mem_exp_q.size() != 0) chk("mem_rdata", 64'(bus.mem_rdata), 64'(mem_exp_q.pop_front()));
      end
      mem_pend = 0;
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic mr,
                       input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.mem_req   = mr;
    bus.mem_we    = mw;
    bus.mem_addr  = ma;
    bus.mem_wdata = md;
  endtask

  task automatic settle();
    #1;
    sb_sample();
  endtask

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          mr;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          rdy;
    logic [1:0]    e_state;
    logic          e_m_req;
    logic [AW-1:0] e_m_addr;
    logic          e_if_done;
    logic          e_mem_done;
    logic [3:0]    e_streak;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic mr,
                              input logic mw, input logic [31:0] ma, input logic [31:0] md,
                              input logic rdy, input logic [1:0] st, input logic mq,
                              input logic [31:0] madr, input logic idn, input logic mdn,
                              input logic [3:0] stk);
    vec_t v;
    v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.md = md; v.rdy = rdy;
    v.e_state = st; v.e_m_req = mq; v.e_m_addr = madr;
    v.e_if_done = idn; v.e_mem_done = mdn; v.e_streak = stk;
    return v;
  endfunction

  initial begin
    // Idle m_ready pulses, zero-wait fetch, streak build-up to the forced IF grant, store.
    vecs[0]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 0);
    vecs[1]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         0, ARB_IDLE, 0, 32'h0,   0, 0, 0);
    vecs[2]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 0);
    vecs[3]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,         1, ARB_IF,   1, 32'h40,  1, 0, 0);
    vecs[4]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 0);
    vecs[5]  = mk(1, 32'h80, 1, 0, 32'h200, 32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 0);
    vecs[6]  = mk(0, 32'h80, 1, 0, 32'h200, 32'h0,         1, ARB_MEM,  1, 32'h200, 0, 1, 1);
    vecs[7]  = mk(1, 32'h80, 1, 0, 32'h204, 32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 1);
    vecs[8]  = mk(0, 32'h80, 1, 0, 32'h204, 32'h0,         1, ARB_MEM,  1, 32'h204, 0, 1, 2);
    vecs[9]  = mk(1, 32'h80, 1, 0, 32'h208, 32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 2);
    vecs[10] = mk(0, 32'h80, 1, 0, 32'h208, 32'h0,         1, ARB_MEM,  1, 32'h208, 0, 1, 3);
    vecs[11] = mk(1, 32'h80, 1, 0, 32'h20C, 32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 3);
    vecs[12] = mk(0, 32'h80, 1, 0, 32'h20C, 32'h0,         1, ARB_MEM,  1, 32'h20C, 0, 1, 4);
    vecs[13] = mk(1, 32'h80, 1, 0, 32'h210, 32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 4);
    vecs[14] = mk(1, 32'h80, 1, 0, 32'h210, 32'h0,         1, ARB_IF,   1, 32'h80,  1, 0, 0);
    vecs[15] = mk(0, 32'h0,  1, 0, 32'h210, 32'h0,         1, ARB_MEM,  1, 32'h210, 0, 1, 1);
    vecs[16] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 1);
    vecs[17] = mk(0, 32'h0,  1, 1, 32'h300, 32'h1234_5678, 1, ARB_IDLE, 0, 32'h0,   0, 0, 1);
    vecs[18] = mk(0, 32'h0,  1, 1, 32'h300, 32'h1234_5678, 1, ARB_MEM,  1, 32'h300, 0, 1, 0);
    vecs[19] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         1, ARB_IDLE, 0, 32'h0,   0, 0, 0);

    drive(0, '0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state",   64'(dbg_state),   64'(ARB_IDLE));
    chk("rst_m_req",   64'(bus.m_req),   64'd0);
    chk("rst_m_we",    64'(bus.m_we),    64'd0);
    chk("rst_m_addr",  64'(bus.m_addr),  64'd0);
    chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    chk("rst_streak",  64'(dbg_streak),  64'd0);
    chk("rst_dones",   64'({bus.if_done, bus.mem_done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].ir, vecs[i].ia, vecs[i].mr, vecs[i].mw, vecs[i].ma, vecs[i].md);
      man_ready = vecs[i].rdy;
      settle();
      chk($sformatf("v%0d_state", i),    64'(dbg_state),    64'(vecs[i].e_state));
      chk($sformatf("v%0d_m_req", i),    64'(bus.m_req),    64'(vecs[i].e_m_req));
      if (vecs[i].e_m_req)
        chk($sformatf("v%0d_m_addr", i), 64'(bus.m_addr),   64'(vecs[i].e_m_addr));
      chk($sformatf("v%0d_if_done", i),  64'(bus.if_done),  64'(vecs[i].e_if_done));
      chk($sformatf("v%0d_mem_done", i), 64'(bus.mem_done), 64'(vecs[i].e_mem_done));
      chk($sformatf("v%0d_streak", i),   64'(dbg_streak),   64'(vecs[i].e_streak));
      chk($sformatf("v%0d_if_stall", i),  64'(bus.if_stall),  64'(vecs[i].ir & ~vecs[i].e_if_done));
      chk($sformatf("v%0d_mem_stall", i), 64'(bus.mem_stall), 64'(vecs[i].mr & ~vecs[i].e_mem_done));
    end

    // Simultaneous store + fetch, 3 wait states: MEM first, IF follows with no gap.
    auto_mode = 1'b1;
    ws = 8'd3;
    @(negedge clk);
    drive(1, 32'h500, 1, 1, 32'h100, 32'hCAFE_0001);
    settle();
    chk("ws_idle", 64'(dbg_state), 64'(ARB_IDLE));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 5) bus.mem_req = 1'b0;
      if (k == 9) bus.if_req = 1'b0;
      settle();
      if (k <= 4) begin
        chk($sformatf("ws%0d_state", k),    64'(dbg_state), 64'(ARB_MEM));
        chk($sformatf("ws%0d_m_beat", k),   {31'd0, bus.m_req, bus.m_we, bus.m_addr}, {31'd0, 1'b1, 1'b1, 32'h100});
        chk($sformatf("ws%0d_m_wdata", k),  64'(bus.m_wdata), 64'h0CAFE_0001);
        chk($sformatf("ws%0d_mem_done", k), 64'(bus.mem_done), 64'(k == 4));
      end else if (k <= 8) begin
        chk($sformatf("ws%0d_state", k),    64'(dbg_state), 64'(ARB_IF));
        chk($sformatf("ws%0d_m_beat", k),   {31'd0, bus.m_req, bus.m_we, bus.m_addr}, {31'd0, 1'b1, 1'b0, 32'h500});
        chk($sformatf("ws%0d_if_done", k),  64'(bus.if_done), 64'(k == 8));
      end else begin
        chk("ws9_state", 64'(dbg_state), 64'(ARB_IDLE));
      end
      if (k == 1) chk("ws_streak_mem", 64'(dbg_streak), 64'd1);
      if (k == 5) chk("ws_streak_if",  64'(dbg_streak), 64'd0);
    end

    // Memory stalls 10 cycles while requester inputs wander: m_* must not move.
    ws = 8'd10;
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h600, 32'hAAAA_5555);
    settle();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 10) begin
        bus.if_addr   = $urandom;
        bus.mem_addr  = $urandom;
        bus.mem_we    = 1'($urandom_range(0, 1));
        bus.mem_wdata = $urandom;
      end else if (k == 11) begin
        drive(0, 32'h0, 1, 0, 32'h600, 32'hAAAA_5555);
      end else begin
        bus.mem_req = 1'b0;
      end
      settle();
      if (k <= 10) begin
        chk($sformatf("hold%0d_m_beat", k), {31'd0, bus.m_req, bus.m_we, bus.m_addr}, {31'd0, 1'b1, 1'b0, 32'h600});
        chk($sformatf("hold%0d_m_wdata", k), 64'(bus.m_wdata), 64'hAAAA_5555);
        chk($sformatf("hold%0d_dones", k), 64'({bus.if_done, bus.mem_done}), 64'd0);
      end else if (k == 11) begin
        chk("hold11_mem_done", 64'(bus.mem_done), 64'd1);
      end else begin
        chk("hold12_state", 64'(dbg_state), 64'(ARB_IDLE));
      end
    end

    // Reset while serving MEM; the abandoned load must never complete.
    ws = 8'd5;
    @(negedge clk);
    drive(1, 32'h740, 1, 0, 32'h700, 32'h0);
    settle();
    repeat (2) begin
      @(negedge clk);
      settle();
    end
    chk("rstmid_pre_state", 64'(dbg_state), 64'(ARB_MEM));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_req",    64'(bus.m_req),    64'd0);
    chk("rstmid_state",    64'(dbg_state),    64'(ARB_IDLE));
    chk("rstmid_mem_done", 64'(bus.mem_done), 64'd0);
    mem_exp_q.delete();
    mem_pend = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_req = 1'b0;
    settle();
    chk("rstrel_state",  64'(dbg_state),  64'(ARB_IDLE));
    chk("rstrel_streak", 64'(dbg_streak), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 7) bus.if_req = 1'b0;
      settle();
      chk($sformatf("rr%0d_mem_done", k), 64'(bus.mem_done), 64'd0);
      if (k <= 6) begin
        chk($sformatf("rr%0d_state", k),   64'(dbg_state),   64'(ARB_IF));
        chk($sformatf("rr%0d_m_addr", k),  64'(bus.m_addr),  64'h740);
        chk($sformatf("rr%0d_if_done", k), 64'(bus.if_done), 64'(k == 6));
      end else begin
        chk("rr7_state", 64'(dbg_state), 64'(ARB_IDLE));
      end
    end

    chk("if_q_drained",  64'(if_exp_q.size()),  64'd0);
    chk("mem_q_drained", 64'(mem_exp_q.size()), 64'd0);
    chk("st_q_drained",  64'(st_exp_q.size()),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
